// File: rtl/alu_issue_controller_if.sv
// Command and issue channels of the ALU issue controller, grouped as one bus.
// slave is the controller's view; master is the instruction-source/ALU side.
interface alu_issue_controller_if #(
   parameter int WIDTH = 8
) ();
   logic             Cmd_Valid;
   logic             Cmd_Ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       Opcode;
   logic             Issue_Valid;
   logic             Issue_Ready;
   logic [3:0]       Controller_Output;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic [2:0]       Select;

   modport slave (
      input  Cmd_Valid, A, B, Opcode, Issue_Ready,
      output Cmd_Ready, Issue_Valid, Controller_Output, dataA, dataB, Select
   );

   modport master (
      output Cmd_Valid, A, B, Opcode, Issue_Ready,
      input  Cmd_Ready, Issue_Valid, Controller_Output, dataA, dataB, Select
   );
endinterface

// File: rtl/alu_issue_controller.sv
// Queued ALU opcode controller: decode at FIFO write, registered issue stage.
// Optional macro ALU_ISSUE_DROP_ILLEGAL_EN: opcode 15 is accepted and counted but never enqueued.
module alu_issue_controller #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Flush,
   alu_issue_controller_if.slave bus,
   output logic [LW-1:0]         Level,
   output logic                  Illegal,
   output logic [7:0]            Illegal_Count
);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = 4 + 2 * WIDTH + 3;
   localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);
   localparam logic [LW-1:0] LVL_ONE    = LW'(1'b1);
   localparam logic [LW-1:0] LVL_ZERO   = LW'(1'b0);
   localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
   localparam logic [WIDTH-1:0] D_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] D_ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] D_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [EW-1:0] IDLE_BUNDLE = {4'hF, D_ZERO, D_ZERO, 3'b100};

   // Bundle layout: {opcode, dataA, dataB, select}
   function automatic logic [EW-1:0] decode(input logic [3:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
      case (op)
         4'h0:                      decode = {op, a, D_ONES, 3'd0};
         4'h1, 4'h4:                decode = {op, a, D_ONE,  3'd1};
         4'h2, 4'h3, 4'h6:          decode = {op, a, b,      3'd1};
         4'h5:                      decode = {op, a, D_ZERO, 3'd1};
         4'h7, 4'h8, 4'h9, 4'hA, 4'hB: decode = {op, a, b,   3'd2};
         4'hC, 4'hD, 4'hE:          decode = {op, a, b,      3'd3};
         default:                   decode = IDLE_BUNDLE;
      endcase
   endfunction

   logic [EW-1:0] mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [LW-1:0] level_r;
   logic [LW-1:0] level_nxt_s;
   logic          cmd_ready_r;
   logic          issue_valid_r;
   logic [EW-1:0] bundle_r;
   logic          illegal_r;
   logic [7:0]    illegal_cnt_r;
   logic          accept_s;
   logic          illegal_in_s;
   logic          push_s;
   logic          pop_s;

   // Handshake qualification and next occupancy; Flush overrides push and pop
   always_comb begin
      accept_s     = bus.Cmd_Valid && cmd_ready_r && !Flush;
      illegal_in_s = (bus.Opcode == 4'hF);
`ifdef ALU_ISSUE_DROP_ILLEGAL_EN
      push_s       = accept_s && !illegal_in_s;
`else
      push_s       = accept_s;
`endif
      pop_s        = (level_r != LVL_ZERO) && (!issue_valid_r || bus.Issue_Ready) && !Flush;
      level_nxt_s  = level_r;
      if (Flush) begin
         level_nxt_s = LVL_ZERO;
      end else begin
         case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
         endcase
      end
   end

   // Queue storage; contents are don't-care once Level says the slot is empty
   always_ff @(posedge Clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= decode(bus.Opcode, bus.A, bus.B);
      end
   end

   // Pointers, occupancy, issue stage and illegal tracking
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_r      <= {PW{1'b0}};
         rd_ptr_r      <= {PW{1'b0}};
         level_r       <= LVL_ZERO;
         cmd_ready_r   <= 1'b1;
         issue_valid_r <= 1'b0;
         bundle_r      <= IDLE_BUNDLE;
         illegal_r     <= 1'b0;
         illegal_cnt_r <= 8'h00;
      end else begin
         level_r     <= level_nxt_s;
         cmd_ready_r <= (level_nxt_s != LVL_FULL);
         illegal_r   <= accept_s && illegal_in_s;
         if (accept_s && illegal_in_s && (illegal_cnt_r != 8'hFF)) begin
            illegal_cnt_r <= illegal_cnt_r + 8'h01;
         end
         if (Flush) begin
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            issue_valid_r <= 1'b0;
            bundle_r      <= IDLE_BUNDLE;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            // A consumed bundle with nothing behind it returns the stage to idle
            if (pop_s) begin
               rd_ptr_r      <= rd_ptr_r + PTR_ONE;
               issue_valid_r <= 1'b1;
               bundle_r      <= mem_r[rd_ptr_r];
            end else if (issue_valid_r && bus.Issue_Ready) begin
               issue_valid_r <= 1'b0;
               bundle_r      <= IDLE_BUNDLE;
            end
         end
      end
   end

   assign bus.Cmd_Ready   = cmd_ready_r;
   assign bus.Issue_Valid = issue_valid_r;
   assign {bus.Controller_Output, bus.dataA, bus.dataB, bus.Select} = bundle_r;
   assign Level           = level_r;
   assign Illegal         = illegal_r;
   assign Illegal_Count   = illegal_cnt_r;
endmodule

// File: tb/tb_alu_issue_controller.sv
// Self-checking bench for alu_issue_controller: opcode table plus backpressure,
// flush and asynchronous-reset sequences, with a scoreboard on the issue channel.
module tb_alu_issue_controller;
   typedef struct packed {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [22:0] exp;
   } vec_t;

   localparam int NV = 17;

   logic       Clk;
   logic       Reset;
   logic       Flush;
   logic [2:0] Level;
   logic       Illegal;
   logic [7:0] Illegal_Count;

   alu_issue_controller_if #(.WIDTH(8)) bus ();

   alu_issue_controller #(.WIDTH(8), .DEPTH(4)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Flush         (Flush),
      .bus           (bus),
      .Level         (Level),
      .Illegal       (Illegal),
      .Illegal_Count (Illegal_Count)
   );

   int          checks = 0;
   int          errors = 0;
   vec_t        vecs [NV];
   logic [22:0] sb [$];
   logic [22:0] cur_exp;
   logic [3:0]  cur_op;
   int          n_illegal;
   bit          acc;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [22:0] bundle();
      return {bus.Controller_Output, bus.dataA, bus.dataB, bus.Select};
   endfunction

   task automatic drive(input vec_t v);
      bus.Cmd_Valid = 1'b1;
      bus.A         = v.a;
      bus.B         = v.b;
      bus.Opcode    = v.op;
      cur_exp       = v.exp;
      cur_op        = v.op;
   endtask

   // Sample both handshakes on the falling edge, then advance past the rising edge
   task automatic tick(output bit accepted);
      logic [22:0] e;
      @(negedge Clk);
      accepted = bus.Cmd_Valid && bus.Cmd_Ready && !Flush;
      if (bus.Issue_Valid && bus.Issue_Ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got bundle %0h, required no issue", bundle());
         end else begin
            e = sb.pop_front();
            chk("issue_bundle", {9'h0, bundle()}, {9'h0, e});
         end
      end
      if (accepted) begin
`ifdef ALU_ISSUE_DROP_ILLEGAL_EN
         if (cur_op != 4'hF) sb.push_back(cur_exp);
`else
         sb.push_back(cur_exp);
`endif
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick(acc);
      tick(acc);
      chk("drain_empty", sb.size(), 0);
   endtask

   initial begin
      vecs[0]  = '{4'h0, 8'h10, 8'h77, {4'h0, 8'h10, 8'hFF, 3'd0}};
      vecs[1]  = '{4'h1, 8'h10, 8'h77, {4'h1, 8'h10, 8'h01, 3'd1}};
      vecs[2]  = '{4'h4, 8'h10, 8'h77, {4'h4, 8'h10, 8'h01, 3'd1}};
      vecs[3]  = '{4'h2, 8'h3C, 8'h05, {4'h2, 8'h3C, 8'h05, 3'd1}};
      vecs[4]  = '{4'h3, 8'hA5, 8'h5A, {4'h3, 8'hA5, 8'h5A, 3'd1}};
      vecs[5]  = '{4'h5, 8'hF0, 8'h33, {4'h5, 8'hF0, 8'h00, 3'd1}};
      vecs[6]  = '{4'h6, 8'h0F, 8'hF0, {4'h6, 8'h0F, 8'hF0, 3'd1}};
      vecs[7]  = '{4'h7, 8'h11, 8'h22, {4'h7, 8'h11, 8'h22, 3'd2}};
      vecs[8]  = '{4'h8, 8'h80, 8'h01, {4'h8, 8'h80, 8'h01, 3'd2}};
      vecs[9]  = '{4'h9, 8'hFF, 8'h00, {4'h9, 8'hFF, 8'h00, 3'd2}};
      vecs[10] = '{4'hA, 8'h55, 8'hAA, {4'hA, 8'h55, 8'hAA, 3'd2}};
      vecs[11] = '{4'hB, 8'hC3, 8'h3C, {4'hB, 8'hC3, 8'h3C, 3'd2}};
      vecs[12] = '{4'hC, 8'h01, 8'h02, {4'hC, 8'h01, 8'h02, 3'd3}};
      vecs[13] = '{4'hD, 8'hFE, 8'hFF, {4'hD, 8'hFE, 8'hFF, 3'd3}};
      vecs[14] = '{4'hE, 8'h7E, 8'h7E, {4'hE, 8'h7E, 8'h7E, 3'd3}};
      vecs[15] = '{4'hF, 8'h12, 8'h34, {4'hF, 8'h00, 8'h00, 3'd4}};
      vecs[16] = '{4'hF, 8'hFF, 8'hFF, {4'hF, 8'h00, 8'h00, 3'd4}};

      Reset = 1'b1;
      Flush = 1'b0;
      bus.Cmd_Valid   = 1'b0;
      bus.A           = 8'h00;
      bus.B           = 8'h00;
      bus.Opcode      = 4'h0;
      bus.Issue_Ready = 1'b1;
      cur_exp = 23'h0;
      cur_op  = 4'h0;
      #12;
      chk("rst_cmd_ready", bus.Cmd_Ready, 1);
      chk("rst_issue_valid", bus.Issue_Valid, 0);
      chk("rst_bundle", {9'h0, bundle()}, {9'h0, 4'hF, 8'h00, 8'h00, 3'b100});
      chk("rst_level", Level, 0);
      chk("rst_illegal", Illegal, 0);
      chk("rst_illegal_count", Illegal_Count, 0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;

      // Latency: accepted at edge N, valid after edge N+1
      drive(vecs[3]);
      tick(acc);
      bus.Cmd_Valid = 1'b0;
      chk("lat_accept", acc, 1);
      chk("lat_valid_n", bus.Issue_Valid, 0);
      chk("lat_level_n", Level, 1);
      tick(acc);
      chk("lat_valid_n1", bus.Issue_Valid, 1);
      chk("lat_bundle", {9'h0, bundle()}, {9'h0, 4'h2, 8'h3C, 8'h05, 3'd1});
      tick(acc);
      chk("idle_valid", bus.Issue_Valid, 0);
      chk("idle_opcode", bus.Controller_Output, 4'hF);

      // Opcode table back to back with the ALU always ready
      n_illegal = 0;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         tick(acc);
         chk("tbl_accept", acc, 1);
         chk("tbl_illegal_pulse", Illegal, (vecs[i].op == 4'hF) ? 1 : 0);
         if (vecs[i].op == 4'hF) n_illegal++;
      end
      bus.Cmd_Valid = 1'b0;
      tick(acc);
      chk("tbl_illegal_clear", Illegal, 0);
      chk("tbl_illegal_count", Illegal_Count, n_illegal);
      drain();

      // Backpressure: one in the issue stage plus four queued fills the FIFO
      bus.Issue_Ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i]);
         tick(acc);
         chk("bp_accept", acc, 1);
      end
      chk("bp_level_full", Level, 4);
      chk("bp_ready_low", bus.Cmd_Ready, 0);
      drive(vecs[5]);
      for (int i = 0; i < 2; i++) begin
         tick(acc);
         chk("bp_refused", acc, 0);
         chk("bp_hold_valid", bus.Issue_Valid, 1);
         chk("bp_hold_bundle", {9'h0, bundle()}, {9'h0, vecs[0].exp});
         chk("bp_hold_level", Level, 4);
      end
      bus.Issue_Ready = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) tick(acc);
      chk("bp_late_accept", acc, 1);
      bus.Cmd_Valid = 1'b0;
      drain();
      chk("bp_level_empty", Level, 0);

      // Flush with a command presented in the same cycle
      bus.Issue_Ready = 1'b0;
      for (int i = 6; i < 10; i++) begin
         drive(vecs[i]);
         tick(acc);
      end
      chk("fl_level_pre", Level, 3);
      drive(vecs[10]);
      Flush = 1'b1;
      tick(acc);
      Flush = 1'b0;
      bus.Cmd_Valid = 1'b0;
      sb.delete();
      chk("fl_level", Level, 0);
      chk("fl_valid", bus.Issue_Valid, 0);
      chk("fl_bundle", {9'h0, bundle()}, {9'h0, 4'hF, 8'h00, 8'h00, 3'b100});
      chk("fl_ready", bus.Cmd_Ready, 1);
      chk("fl_illegal_count", Illegal_Count, n_illegal);
      tick(acc);
      chk("fl_not_accepted", Level, 0);

      // Asynchronous reset between edges with two entries queued
      for (int i = 2; i < 5; i++) begin
         drive(vecs[i]);
         tick(acc);
      end
      bus.Cmd_Valid = 1'b0;
      chk("ar_level_pre", Level, 2);
      #2;
      Reset = 1'b1;
      #1;
      chk("ar_level", Level, 0);
      chk("ar_valid", bus.Issue_Valid, 0);
      chk("ar_ready", bus.Cmd_Ready, 1);
      chk("ar_bundle", {9'h0, bundle()}, {9'h0, 4'hF, 8'h00, 8'h00, 3'b100});
      chk("ar_illegal_count", Illegal_Count, 0);
      sb.delete();
      Reset = 1'b0;
      bus.Issue_Ready = 1'b1;
      drive(vecs[7]);
      tick(acc);
      bus.Cmd_Valid = 1'b0;
      chk("ar_post_accept", acc, 1);
      tick(acc);
      chk("ar_post_valid", bus.Issue_Valid, 1);
      chk("ar_post_bundle", {9'h0, bundle()}, {9'h0, vecs[7].exp});
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
